// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared state encoding and overflow-mode constants for the perf monitor
package perf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SAT_WRAP = 0;
   localparam int SAT_HOLD = 1;

endpackage

// File: rtl/perf_event_counter.sv
// rtl/perf_event_counter.sv - one live counter with shadow copy, sticky overflow and optional limit detect
module perf_event_counter
   import perf_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = SAT_WRAP,
   parameter int LIMIT    = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc,
   input  logic             clr,
   input  logic             snap,
   output logic [CNT_W-1:0] shadow,
   output logic             ovf,
   output logic             limit_hit
);

   // Value the live count holds on the edge that will bring it up to LIMIT
   localparam logic [CNT_W-1:0] LIMIT_M1 = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

   logic [CNT_W-1:0] live;
   logic             all_ones;

   assign all_ones  = &live;
   assign limit_hit = (LIMIT != 0) && (live == LIMIT_M1);

   // Live count, shadow capture (pre-increment value) and sticky overflow; clear wins over everything
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         live   <= '0;
         shadow <= '0;
         ovf    <= 1'b0;
      end else if (clr) begin
         live   <= '0;
         shadow <= '0;
         ovf    <= 1'b0;
      end else begin
         if (snap) begin
            shadow <= live;
         end
         if (inc) begin
            if (all_ones) begin
               ovf <= 1'b1;
               if (SAT_MODE == SAT_WRAP) begin
                  live <= '0;
               end
            end else begin
               live <= live + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - pipeline performance monitor: run FSM, cycle/event counters and shadow read mux
module pipe_perf_monitor
   import perf_pkg::*;
#(
   parameter int N_EVT       = 4,
   parameter int CNT_W       = 32,
   parameter int SAT_MODE    = SAT_WRAP,
   parameter int CYCLE_LIMIT = 100,
   parameter int SEL_W       = $clog2(N_EVT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             clear_i,
   input  logic             snap_i,
   input  logic [N_EVT-1:0] evt_i,
   input  logic [SEL_W-1:0] rd_sel_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic [N_EVT:0]   ovf_o,
   output logic             running_o,
   output logic             done_o
);

   state_t           state;
   logic             count_en;
   logic             limit_hit;
   logic [N_EVT:0]   inc_vec;
   logic [N_EVT:0]   hit_vec;
   logic [CNT_W-1:0] shadow [N_EVT+1];

   assign count_en  = (state == ST_RUN);
   assign inc_vec   = {evt_i, 1'b1} & {(N_EVT + 1){count_en}};
   // Only the cycle channel carries a nonzero limit, so the OR is the cycle-limit strobe
   assign limit_hit = |hit_vec;
   assign running_o = (state == ST_RUN);
   assign done_o    = (state == ST_DONE);

   // Run control: limit completion beats a pause request; DONE leaves only through clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else if (clear_i) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start_i) state <= ST_RUN;
            ST_RUN: begin
               if (limit_hit) begin
                  state <= ST_DONE;
               end else if (!start_i) begin
                  state <= ST_IDLE;
               end
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Channel 0 counts cycles, channel k+1 counts event k
   for (genvar g = 0; g <= N_EVT; g++) begin : g_chan
      perf_event_counter #(
         .CNT_W    (CNT_W),
         .SAT_MODE (SAT_MODE),
         .LIMIT    ((g == 0) ? CYCLE_LIMIT : 0)
      ) u_cnt (
         .clk_i     (clk_i),
         .rst_i     (rst_i),
         .inc       (inc_vec[g]),
         .clr       (clear_i),
         .snap      (snap_i),
         .shadow    (shadow[g]),
         .ovf       (ovf_o[g]),
         .limit_hit (hit_vec[g])
      );
   end

   // Shadow read mux; selects beyond the last channel read as zero
   always_comb begin
      rd_data_o = '0;
      for (int k = 0; k <= N_EVT; k++) begin
         if (rd_sel_i == SEL_W'(k)) begin
            rd_data_o = shadow[k];
         end
      end
   end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - directed self-checking bench for pipe_perf_monitor
module tb_pipe_perf_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start = 1'b0, clear = 1'b0, snap = 1'b0;
   logic [3:0]  evt = '0;
   logic [2:0]  sel = '0;
   logic [31:0] rd;
   logic [4:0]  ovf;
   logic        running, done;

   logic        start_s = 1'b0, clear_s = 1'b0, snap_s = 1'b0;
   logic [3:0]  evt_s = '0;
   logic [2:0]  sel_s = '0;
   logic [3:0]  rd_w, rd_h;
   logic [4:0]  ovf_w, ovf_h;
   logic        run_w, done_w, run_h, done_h;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_perf_monitor #(.N_EVT(4), .CNT_W(32), .SAT_MODE(0), .CYCLE_LIMIT(100)) u_main (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .snap_i(snap),
      .evt_i(evt), .rd_sel_i(sel), .rd_data_o(rd), .ovf_o(ovf),
      .running_o(running), .done_o(done)
   );

   pipe_perf_monitor #(.N_EVT(4), .CNT_W(4), .SAT_MODE(0), .CYCLE_LIMIT(0)) u_wrap (
      .clk_i(clk), .rst_i(rst), .start_i(start_s), .clear_i(clear_s), .snap_i(snap_s),
      .evt_i(evt_s), .rd_sel_i(sel_s), .rd_data_o(rd_w), .ovf_o(ovf_w),
      .running_o(run_w), .done_o(done_w)
   );

   pipe_perf_monitor #(.N_EVT(4), .CNT_W(4), .SAT_MODE(1), .CYCLE_LIMIT(0)) u_sat (
      .clk_i(clk), .rst_i(rst), .start_i(start_s), .clear_i(clear_s), .snap_i(snap_s),
      .evt_i(evt_s), .rd_sel_i(sel_s), .rd_data_o(rd_h), .ovf_o(ovf_h),
      .running_o(run_h), .done_o(done_h)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_main(input logic [2:0] s, input string tag, input logic [31:0] exp);
      sel = s;
      #1;
      chk(tag, rd, exp);
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_running", {31'b0, running}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_ovf", {27'b0, ovf}, 32'd0);
      chk("rst_rd", rd, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick(2);
      chk("idle_no_start", {31'b0, running}, 32'd0);

      // Pause/resume: 10 counted, 5 paused edges with events, 7 counted
      start = 1'b1;
      tick(1);
      chk("run_entered", {31'b0, running}, 32'd1);
      tick(9);
      start = 1'b0;
      tick(1);
      chk("paused", {31'b0, running}, 32'd0);
      evt = 4'hF;
      tick(2);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      read_main(3'd0, "pause_snap", 32'd10);
      tick(1);
      evt = 4'h0;
      start = 1'b1;
      tick(1);
      tick(6);
      start = 1'b0;
      tick(1);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      read_main(3'd0, "resume_total", 32'd17);
      read_main(3'd1, "pause_evt_ignored", 32'd0);

      // Limit run: evt0 every 4th counted cycle, evt1 on odd counted cycles
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      read_main(3'd0, "clear_shadow", 32'd0);
      start = 1'b1;
      evt = 4'hF;
      tick(1);
      for (int c = 1; c <= 100; c++) begin
         evt = {2'b00, (c % 2 == 1), (c % 4 == 0)};
         tick(1);
      end
      chk("limit_done", {31'b0, done}, 32'd1);
      chk("limit_running", {31'b0, running}, 32'd0);
      evt = 4'hF;
      tick(5);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      evt = 4'h0;
      read_main(3'd0, "limit_cycles", 32'd100);
      read_main(3'd1, "limit_evt0", 32'd25);
      read_main(3'd2, "limit_evt1", 32'd50);
      read_main(3'd3, "limit_evt2", 32'd0);
      read_main(3'd5, "sel_n_evt_plus1", 32'd0);
      read_main(3'd7, "sel_max", 32'd0);
      chk("done_sticky", {31'b0, done}, 32'd1);

      // Snapshot with simultaneous event, then clear+snap+evt+start together
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(1);
      evt = 4'b0010;
      tick(5);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      read_main(3'd0, "snap_pre_cycle", 32'd5);
      read_main(3'd2, "snap_pre_evt1", 32'd5);
      evt = 4'h0;
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      read_main(3'd2, "snap_post_evt1", 32'd6);
      clear = 1'b1;
      snap = 1'b1;
      evt = 4'hF;
      tick(1);
      clear = 1'b0;
      snap = 1'b0;
      evt = 4'h0;
      chk("clr_prio_state", {31'b0, running}, 32'd0);
      chk("clr_prio_ovf", {27'b0, ovf}, 32'd0);
      read_main(3'd0, "clr_prio_cycle", 32'd0);
      read_main(3'd2, "clr_prio_evt1", 32'd0);
      tick(1);
      chk("restart_after_clr", {31'b0, running}, 32'd1);
      tick(2);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      read_main(3'd0, "restart_count", 32'd2);

      // Async reset at counted cycle 37
      start = 1'b0;
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      start = 1'b1;
      tick(1);
      tick(30);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      tick(6);
      read_main(3'd0, "pre_rst_shadow", 32'd30);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_rd", rd, 32'd0);
      chk("async_rst_running", {31'b0, running}, 32'd0);
      chk("async_rst_done", {31'b0, done}, 32'd0);
      #1;
      rst = 1'b0;
      start = 1'b0;
      tick(3);
      chk("post_rst_idle", {31'b0, running}, 32'd0);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      read_main(3'd0, "post_rst_nocount", 32'd0);
      start = 1'b1;
      tick(1);
      tick(3);
      snap = 1'b1;
      tick(1);
      snap = 1'b0;
      read_main(3'd0, "post_rst_recount", 32'd3);
      start = 1'b0;

      // Overflow on 4-bit counters: 18 counted events on channel 0
      start_s = 1'b1;
      tick(1);
      evt_s = 4'b0001;
      tick(17);
      start_s = 1'b0;
      tick(1);
      evt_s = 4'b0000;
      snap_s = 1'b1;
      tick(1);
      snap_s = 1'b0;
      sel_s = 3'd1;
      #1;
      chk("wrap_evt0", {28'b0, rd_w}, 32'd2);
      chk("sat_evt0", {28'b0, rd_h}, 32'd15);
      chk("wrap_ovf", {27'b0, ovf_w}, 32'd3);
      chk("sat_ovf", {27'b0, ovf_h}, 32'd3);
      sel_s = 3'd0;
      #1;
      chk("wrap_cycle", {28'b0, rd_w}, 32'd2);
      chk("sat_cycle", {28'b0, rd_h}, 32'd15);
      tick(3);
      chk("ovf_sticky", {27'b0, ovf_w}, 32'd3);
      clear_s = 1'b1;
      tick(1);
      clear_s = 1'b0;
      chk("ovf_cleared", {27'b0, ovf_w}, 32'd0);
      chk("wrap_cleared_rd", {28'b0, rd_w}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_perf_monitor.md
PIPE_PERF_MONITOR -- requirements
Module: pipe_perf_monitor

Interface
REQ-001 SHALL have parameter N_EVT, default 4, number of event channels (stall, flush, retire, spare).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter.
REQ-003 SHALL have parameter SAT_MODE, default 0: 0 = wrap on overflow, 1 = saturate at all-ones.
REQ-004 SHALL have parameter CYCLE_LIMIT, default 100: run length in counted cycles; 0 = unlimited.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk_i  input  1  clock; all state updates on its rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 start_i  input  1  level run enable.
REQ-009 clear_i  input  1  synchronous clear pulse.
REQ-010 snap_i  input  1  snapshot pulse that copies live counters to shadow registers.
REQ-011 evt_i  input  N_EVT  per-channel event strobes, one count per asserted cycle.
REQ-012 rd_sel_i  input  SEL_W=$clog2(N_EVT+1)  shadow select: 0 = cycle, k+1 = event k.
REQ-013 rd_data_o  output  CNT_W  selected shadow value.
REQ-014 ovf_o  output  N_EVT+1  sticky overflow flags: bit 0 = cycle, bit k+1 = event k.
REQ-015 running_o  output  1  high while state is RUN.
REQ-016 done_o  output  1  high while state is DONE.

Function
REQ-017 SHALL implement the states IDLE, RUN and DONE.
REQ-018 Transitions: IDLE->RUN when start_i=1; RUN->IDLE when start_i=0, with counters held (pause); RUN->DONE on the edge where the cycle counter reaches CYCLE_LIMIT, if CYCLE_LIMIT!=0; DONE is exited only by clear_i.
REQ-019 Counting SHALL occur only on edges where the registered state is RUN: the cycle counter increments by 1, and event counter k increments by 1 iff evt_i[k]=1.
REQ-020 The edge that moves IDLE->RUN SHALL NOT count, so the first count happens on the second edge with start_i high.
REQ-021 The edge that moves RUN->DONE SHALL still count, leaving the cycle counter exactly equal to CYCLE_LIMIT.
REQ-022 Overflow when SAT_MODE=0: an all-ones counter incremented becomes 0 and its ovf_o bit is set.
REQ-023 Overflow when SAT_MODE=1: the counter holds all-ones and its ovf_o bit is set.
REQ-024 ovf_o bits SHALL remain set until clear_i or reset.
REQ-025 On snap_i=1, all shadows SHALL load the pre-increment live values atomically on the same edge.
REQ-026 rd_data_o SHALL be a combinational mux of the shadows, and SHALL be 0 for rd_sel_i > N_EVT.
REQ-027 On clear_i=1: live counters, shadows and ovf_o SHALL be zeroed and the state SHALL go to IDLE.
REQ-028 clear_i SHALL take priority over start_i, snap_i, evt_i and the limit transition in the same cycle.
REQ-029 snap_i SHALL be honoured in any state.
REQ-030 Events arriving in IDLE or DONE SHALL be ignored.
REQ-031 running_o and done_o SHALL be registered-state decodes with zero-cycle latency from the state.

Reset
REQ-032 rst_i high SHALL immediately force state IDLE, all live counters and shadows to 0, ovf_o=0, running_o=0, done_o=0 and rd_data_o=0, regardless of the clock and including mid-run.
REQ-033 After rst_i deasserts, the block SHALL require start_i to be seen high at an edge before any counting.

Structure
REQ-034 State encoding (IDLE/RUN/DONE) and the SAT_MODE constants SHALL live in shared package perf_pkg.
REQ-035 Each channel SHALL be an instance of sub-module perf_event_counter (inc, clr, snap, live, shadow, ovf, wrap/saturate logic); the top instantiates N_EVT+1 copies plus the FSM and read mux.

Verification
REQ-036 Limit run: CYCLE_LIMIT=100, start_i held high, evt_i[0] high every 4th counted cycle -> after snap, sel0=100, sel1=25, done_o=1, running_o=0.
REQ-037 Pause/resume: run 10 cycles, start_i low for 5, high for 7 -> sel0=17, no counts during the pause.
REQ-038 Overflow: CNT_W=4, SAT_MODE=0, 18 counted events on ch0 -> sel1=2, ovf_o[1]=1; with SAT_MODE=1 -> sel1=15, ovf_o[1]=1.
REQ-039 Simultaneous events: clear_i, snap_i and evt_i all high while in RUN -> all shadows 0, state IDLE, ovf_o=0. Separately, snap_i with evt_i in RUN -> shadow equals pre-increment value.
REQ-040 Async reset mid-run at counted cycle 37 -> outputs 0 before the next edge; no counts until start_i is seen high again.
REQ-041 Read mux: rd_sel_i=N_EVT+1 -> rd_data_o=0. DONE with events toggling -> counters unchanged.
